// File: rtl/cic_decim_ctrl.sv
// Decimation-strobe sequencer for the CIC chain: programmable rate R, handshaked
// runtime rate changes committed on a phase boundary, and comb-refill output gating.
module cic_decim_ctrl #(
  parameter int CNT_W    = 8,
  parameter int DEF_RATE = 5,
  parameter int FLUSH_N  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din_valid,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_rate,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             chain_clr,
  output logic             dec_strobe,
  output logic             out_valid,
  output logic [CNT_W-1:0] rate_cur,
  output logic             busy
);

  localparam int FC_W = $clog2(FLUSH_N + 1);

  typedef enum logic [1:0] {IDLE, FLUSH, RUN, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] ph, ph_nxt, ph_adv;
  logic [CNT_W-1:0] rate_nxt, pending, pending_nxt;
  logic [FC_W-1:0]  flush_cnt, flush_nxt;
  logic             strobe_nxt, valid_nxt, clr_nxt, err_nxt;
  logic             accept, rate_ok, boundary;

  assign accept   = cfg_valid && cfg_ready;
  assign rate_ok  = (cfg_rate != '0);
  assign boundary = din_valid && (ph == rate_cur - CNT_W'(1));
  assign ph_adv   = boundary ? '0 : ph + CNT_W'(din_valid);

  // Disable wins over everything; a rate already agreed in DRAIN is still honoured.
  always_comb begin
    state_nxt   = state;
    ph_nxt      = ph;
    rate_nxt    = rate_cur;
    pending_nxt = pending;
    flush_nxt   = flush_cnt;
    strobe_nxt  = 1'b0;
    valid_nxt   = 1'b0;
    clr_nxt     = 1'b0;
    err_nxt     = accept && !rate_ok;
    if (!en) begin
      state_nxt = IDLE;
      ph_nxt    = '0;
      flush_nxt = '0;
      if (state == DRAIN) rate_nxt = pending;
      if (accept && rate_ok) rate_nxt = cfg_rate;
    end else begin
      case (state)
        IDLE: begin
          if (accept && rate_ok) rate_nxt = cfg_rate;
          state_nxt = FLUSH;
          clr_nxt   = 1'b1;
          flush_nxt = FC_W'(FLUSH_N);
          ph_nxt    = '0;
        end
        FLUSH: begin
          ph_nxt     = ph_adv;
          strobe_nxt = boundary;
          if (boundary) begin
            flush_nxt = flush_cnt - FC_W'(1);
            if (flush_cnt == FC_W'(1)) state_nxt = RUN;
          end
        end
        RUN: begin
          ph_nxt     = ph_adv;
          strobe_nxt = boundary;
          valid_nxt  = boundary;
          if (accept && rate_ok) begin
            pending_nxt = cfg_rate;
            state_nxt   = DRAIN;
          end
        end
        DRAIN: begin
          ph_nxt     = ph_adv;
          strobe_nxt = boundary;
          valid_nxt  = boundary;
          // Integrators keep running across the switch, so no chain_clr here.
          if (boundary) begin
            rate_nxt  = pending;
            flush_nxt = FC_W'(FLUSH_N);
            state_nxt = FLUSH;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ph         <= '0;
      rate_cur   <= CNT_W'(DEF_RATE);
      pending    <= '0;
      flush_cnt  <= '0;
      dec_strobe <= 1'b0;
      out_valid  <= 1'b0;
      chain_clr  <= 1'b0;
      cfg_err    <= 1'b0;
      cfg_ready  <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      ph         <= ph_nxt;
      rate_cur   <= rate_nxt;
      pending    <= pending_nxt;
      flush_cnt  <= flush_nxt;
      dec_strobe <= strobe_nxt;
      out_valid  <= valid_nxt;
      chain_clr  <= clr_nxt;
      cfg_err    <= err_nxt;
      cfg_ready  <= (state_nxt == IDLE) || (state_nxt == RUN);
      busy       <= (state_nxt == FLUSH) || (state_nxt == DRAIN);
    end
  end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed bench for cic_decim_ctrl: a sample-counting reference model is compared
// against the DUT every cycle, plus literal event counts per scenario.
module tb_cic_decim_ctrl;

  localparam int CNT_W    = 8;
  localparam int DEF_RATE = 5;
  localparam int FLUSH_N  = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             en, din_valid, cfg_valid;
  logic [CNT_W-1:0] cfg_rate;
  logic             cfg_ready, cfg_err, chain_clr, dec_strobe, out_valid, busy;
  logic [CNT_W-1:0] rate_cur;

  int checks = 0;
  int failures = 0;
  int n_strobe = 0, n_ov = 0, n_clr = 0, n_err = 0;
  int s_strobe, s_ov, s_clr, s_err;

  // Reference model: sample count within the phase, strobes seen since the epoch began.
  bit m_enabled, m_draining;
  int m_rate, m_pending, m_samples, m_strobes;
  bit e_strobe, e_ov, e_clr, e_err;

  cic_decim_ctrl #(.CNT_W(CNT_W), .DEF_RATE(DEF_RATE), .FLUSH_N(FLUSH_N)) dut (
    .clk(clk), .rst(rst), .en(en), .din_valid(din_valid), .cfg_valid(cfg_valid),
    .cfg_rate(cfg_rate), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .chain_clr(chain_clr), .dec_strobe(dec_strobe), .out_valid(out_valid),
    .rate_cur(rate_cur), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic bit modelReady();
    return !m_enabled || (m_strobes >= FLUSH_N && !m_draining);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_enabled = 0; m_draining = 0; m_rate = DEF_RATE; m_pending = 0;
      m_samples = 0; m_strobes = 0;
      e_strobe = 0; e_ov = 0; e_clr = 0; e_err = 0;
    end else begin
      bit accept, was_drain;
      accept    = cfg_valid && modelReady();
      was_drain = m_draining;
      e_strobe = 0; e_ov = 0; e_clr = 0;
      e_err    = accept && (cfg_rate == 0);
      if (!en) begin
        if (m_draining) m_rate = m_pending;
        if (accept && cfg_rate != 0) m_rate = int'(cfg_rate);
        m_enabled = 0; m_draining = 0; m_samples = 0; m_strobes = 0;
      end else if (!m_enabled) begin
        if (accept && cfg_rate != 0) m_rate = int'(cfg_rate);
        m_enabled = 1; m_samples = 0; m_strobes = 0; e_clr = 1;
      end else begin
        if (accept && cfg_rate != 0) begin
          m_draining = 1;
          m_pending  = int'(cfg_rate);
        end
        if (din_valid) begin
          m_samples++;
          if (m_samples == m_rate) begin
            m_samples = 0;
            e_strobe  = 1;
            e_ov      = (m_strobes >= FLUSH_N);
            if (m_strobes < FLUSH_N) m_strobes++;
            if (was_drain) begin
              m_rate = m_pending; m_strobes = 0; m_draining = 0;
            end
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      checkOutput("dec_strobe", dec_strobe, e_strobe);
      checkOutput("out_valid", out_valid, e_ov);
      checkOutput("chain_clr", chain_clr, e_clr);
      checkOutput("cfg_err", cfg_err, e_err);
      checkOutput("rate_cur", rate_cur, m_rate);
      checkOutput("cfg_ready", cfg_ready, modelReady());
      checkOutput("busy", busy, !modelReady());
      n_strobe += dec_strobe; n_ov += out_valid; n_clr += chain_clr; n_err += cfg_err;
    end
  end

  task automatic applyStimulus(input bit e, input bit dv, input bit cv, input int r, input int n);
    for (int i = 0; i < n; i++) begin
      en = e; din_valid = dv; cfg_valid = cv; cfg_rate = CNT_W'(r);
      @(posedge clk);
      #2;
    end
  endtask

  task automatic snap();
    s_strobe = n_strobe; s_ov = n_ov; s_clr = n_clr; s_err = n_err;
  endtask

  task automatic doReset();
    en = 0; din_valid = 0; cfg_valid = 0; cfg_rate = '0;
    rst = 1;
    repeat (2) @(posedge clk);
    #2 rst = 0;
    checkOutput("reset rate_cur", rate_cur, DEF_RATE);
    checkOutput("reset cfg_ready", cfg_ready, 1);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset dec_strobe", dec_strobe, 0);
  endtask

  initial begin
    rst = 1; en = 0; din_valid = 0; cfg_valid = 0; cfg_rate = '0;
    doReset();

    // Start at R=5 with continuous samples: 8 strobes in 40 samples, last 3 valid.
    snap();
    applyStimulus(1, 1, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 40);
    checkOutput("t1 strobes", n_strobe - s_strobe, 8);
    checkOutput("t1 out_valid", n_ov - s_ov, 3);
    checkOutput("t1 chain_clr", n_clr - s_clr, 1);

    // Zero-rate request in RUN is rejected without disturbing the phase.
    snap();
    applyStimulus(1, 1, 1, 0, 1);
    applyStimulus(1, 1, 0, 0, 4);
    checkOutput("t4 cfg_err", n_err - s_err, 1);
    checkOutput("t4 rate_cur", rate_cur, 5);
    checkOutput("t4 strobes", n_strobe - s_strobe, 1);
    checkOutput("t4 out_valid", n_ov - s_ov, 1);

    // Change 5 -> 2 mid-phase: final strobe at old rate, then 5 suppressed at R=2.
    applyStimulus(1, 1, 0, 0, 3);
    snap();
    applyStimulus(1, 0, 1, 2, 1);
    checkOutput("t3 cfg_ready low", cfg_ready, 0);
    checkOutput("t3 busy high", busy, 1);
    applyStimulus(1, 1, 0, 0, 2);
    checkOutput("t3 rate_cur", rate_cur, 2);
    checkOutput("t3 final ov", n_ov - s_ov, 1);
    applyStimulus(1, 1, 0, 0, 12);
    checkOutput("t3 strobes", n_strobe - s_strobe, 7);
    checkOutput("t3 out_valid", n_ov - s_ov, 2);

    // Gappy input at R=3: strobes only after valid samples 3, 6 and 9.
    doReset();
    applyStimulus(0, 0, 1, 3, 1);
    checkOutput("t2 rate_cur", rate_cur, 3);
    snap();
    applyStimulus(1, 0, 0, 0, 1);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 1, 0, 0, 1); applyStimulus(1, 0, 0, 0, 1);
      applyStimulus(1, 1, 0, 0, 2); applyStimulus(1, 0, 0, 0, 2);
      applyStimulus(1, 1, 0, 0, 2);
    end
    checkOutput("t2 strobes", n_strobe - s_strobe, 3);
    checkOutput("t2 chain_clr", n_clr - s_clr, 1);

    // R=1 programmed in IDLE: a strobe per sample, valid from the 6th.
    doReset();
    applyStimulus(0, 0, 1, 1, 1);
    snap();
    applyStimulus(1, 1, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 10);
    checkOutput("t5 rate_cur", rate_cur, 1);
    checkOutput("t5 strobes", n_strobe - s_strobe, 10);
    checkOutput("t5 out_valid", n_ov - s_ov, 5);

    // Disable while draining toward R=8, then re-enable.
    applyStimulus(1, 0, 1, 8, 1);
    checkOutput("t6 busy drain", busy, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t6 rate_cur", rate_cur, 8);
    checkOutput("t6 busy idle", busy, 0);
    checkOutput("t6 cfg_ready", cfg_ready, 1);
    snap();
    applyStimulus(1, 1, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 48);
    checkOutput("t6 chain_clr", n_clr - s_clr, 1);
    checkOutput("t6 strobes", n_strobe - s_strobe, 6);
    checkOutput("t6 out_valid", n_ov - s_ov, 1);

    // Rate request in the same cycle as start applies from the first phase.
    applyStimulus(0, 0, 0, 0, 1);
    snap();
    applyStimulus(1, 1, 1, 4, 1);
    applyStimulus(1, 1, 0, 0, 20);
    checkOutput("t7 rate_cur", rate_cur, 4);
    checkOutput("t7 strobes", n_strobe - s_strobe, 5);

    // Asynchronous reset during DRAIN drops the pending rate immediately.
    applyStimulus(1, 0, 1, 3, 1);
    checkOutput("t8 busy drain", busy, 1);
    rst = 1;
    #1;
    checkOutput("t8 async rate_cur", rate_cur, DEF_RATE);
    checkOutput("t8 async busy", busy, 0);
    checkOutput("t8 async cfg_ready", cfg_ready, 1);
    en = 0; cfg_valid = 0;
    repeat (2) @(posedge clk);
    #2 rst = 0;
    applyStimulus(0, 0, 0, 0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
